// File: rtl/paint_brush_engine_pkg.sv
// paint_brush_engine_pkg: shared state encoding, default geometry and brush-size clamp
package paint_brush_engine_pkg;
  typedef enum logic [1:0] {IDLE, STAMP, CLEAR, DONE} state_t;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  localparam int DEF_MAX_BRUSH = 31;
  localparam int DEF_COLOR_W = 9;
  localparam logic [8:0] DEF_BG_COLOR = 9'h1FF;
  function automatic int clamp_size(input int size, input int max_brush);
    return (size == 0) ? 1 : ((size > max_brush) ? max_brush : size);
  endfunction
endpackage

// File: rtl/paint_brush_engine_if.sv
// paint_brush_engine_if: pixel stream towards the frame-buffer writer (valid/ready)
interface paint_brush_engine_if #(
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOR_W = 9
);
  logic valid;
  logic ready;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [COLOR_W-1:0] color;
  modport master(output valid, x, y, color, input ready);
  modport slave(input valid, x, y, color, output ready);
endinterface

// File: rtl/paint_brush_engine_raster_scan_counter.sv
// paint_brush_engine_raster_scan_counter: row-major 2-D counter with programmable maxima
module paint_brush_engine_raster_scan_counter #(
  parameter int X_W = 9,
  parameter int Y_W = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           clr,
  input  logic           en,
  input  logic [X_W-1:0] max_x,
  input  logic [Y_W-1:0] max_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);
  assign last = (x == max_x) && (y == max_y);
  // x runs fastest; wrapping x steps y, and the final element wraps both to zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      x <= (x == max_x) ? '0 : x + X_W'(1);
      if (x == max_x) y <= (y == max_y) ? '0 : y + Y_W'(1);
    end
  end
endmodule

// File: rtl/paint_brush_engine.sv
// paint_brush_engine: rasterises a clipped brush stamp or a full-screen clear; disc shape with PAINT_BRUSH_DISC_EN
module paint_brush_engine
  import paint_brush_engine_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int MAX_BRUSH = DEF_MAX_BRUSH,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(DEF_BG_COLOR),
  localparam int X_W = $clog2(SCREEN_W),
  localparam int Y_W = $clog2(SCREEN_H),
  localparam int S_W = $clog2(MAX_BRUSH + 1)
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  input  logic               clear_req,
  input  logic [X_W-1:0]     cur_x,
  input  logic [Y_W-1:0]     cur_y,
  input  logic [S_W-1:0]     brush_size,
  input  logic [COLOR_W-1:0] brush_color,
  input  logic               shape,
  output logic               busy,
  output logic               done,
  paint_brush_engine_if.master pix
);
  localparam logic [X_W:0] SW_L = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SH_L = (Y_W + 1)'(SCREEN_H);
  state_t state, state_n;
  logic ended, ended_n;
  logic [X_W-1:0] cx, ox, max_x;
  logic [Y_W-1:0] cy, oy, max_y;
  logic [S_W-1:0] sz, sz_m1, c;
  logic [COLOR_W-1:0] col;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic scan, acc, adv, last, on_screen, keep, wr;

  assign scan = (state == STAMP) || (state == CLEAR);
  assign acc = (state == IDLE) && (start || clear_req);
  assign adv = scan && !ended && (!pix.valid || pix.ready);
  assign busy = scan;
  assign done = state == DONE;
  assign sz_m1 = sz - S_W'(1);
  assign c = sz_m1 >> 1;
  assign max_x = (state == CLEAR) ? X_W'(SCREEN_W - 1) : X_W'(sz_m1);
  assign max_y = (state == CLEAR) ? Y_W'(SCREEN_H - 1) : Y_W'(sz_m1);
  // negative coordinates wrap to >= 2^X_W in X_W+1 bits, so one unsigned compare clips both sides
  assign px = (state == CLEAR) ? {1'b0, ox} : {1'b0, cx} + {1'b0, ox} - (X_W + 1)'(c);
  assign py = (state == CLEAR) ? {1'b0, oy} : {1'b0, cy} + {1'b0, oy} - (Y_W + 1)'(c);
  assign on_screen = (px < SW_L) && (py < SH_L);
  assign wr = (state == CLEAR) || (on_screen && keep);

`ifdef PAINT_BRUSH_DISC_EN
  logic shp;
  logic signed [S_W+1:0] u, v;
  logic [S_W+1:0] au, av;
  logic [2*S_W+1:0] r2, s2;
  assign u = $signed({1'b0, ox[S_W-1:0], 1'b0}) - $signed({2'b00, sz_m1});
  assign v = $signed({1'b0, oy[S_W-1:0], 1'b0}) - $signed({2'b00, sz_m1});
  assign au = u[S_W+1] ? $unsigned(-u) : $unsigned(u);
  assign av = v[S_W+1] ? $unsigned(-v) : $unsigned(v);
  assign r2 = (2*S_W+2)'(au) * (2*S_W+2)'(au) + (2*S_W+2)'(av) * (2*S_W+2)'(av);
  assign s2 = (2*S_W+2)'(sz) * (2*S_W+2)'(sz);
  assign keep = !shp || (r2 <= s2);
  // shape is captured with the rest of the command
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) shp <= 1'b0;
    else if (acc) shp <= shape;
  end
`else
  logic unused_shape;
  assign unused_shape = shape;
  assign keep = 1'b1;
`endif

  paint_brush_engine_raster_scan_counter #(.X_W(X_W), .Y_W(Y_W)) u_scan (
    .clk(CLOCK_50),
    .resetn(resetn),
    .clr(acc),
    .en(adv),
    .max_x(max_x),
    .max_y(max_y),
    .x(ox),
    .y(oy),
    .last(last)
  );

  // state register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ended <= 1'b0;
    end else begin
      state <= state_n;
      ended <= ended_n;
    end
  end

  // next state: ended marks a written final pixel still waiting for its handshake
  always_comb begin
    state_n = state;
    ended_n = 1'b0;
    case (state)
      IDLE: state_n = clear_req ? CLEAR : (start ? STAMP : IDLE);
      STAMP, CLEAR: begin
        ended_n = ended || (adv && last && wr);
        if (ended ? pix.ready : (adv && last && !wr)) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // command latch and pixel output register; the output holds while a pixel is unaccepted
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
      sz <= '0;
      col <= '0;
      pix.valid <= 1'b0;
      pix.x <= '0;
      pix.y <= '0;
      pix.color <= BG_COLOR;
    end else begin
      if (acc) begin
        cx <= cur_x;
        cy <= cur_y;
        sz <= S_W'(clamp_size(int'(brush_size), MAX_BRUSH));
        col <= brush_color;
      end
      pix.valid <= adv ? wr : (pix.valid && !pix.ready);
      if (adv && wr) begin
        pix.x <= px[X_W-1:0];
        pix.y <= py[Y_W-1:0];
        pix.color <= (state == CLEAR) ? BG_COLOR : col;
      end
    end
  end
endmodule

// File: doc/paint_brush_engine.md
Name: paint_brush_engine

Overview:
- Parametrised successor of the fixed-size cursor-square painter: rasterises one brush stamp (square, optionally disc) centred on a latched cursor position, or a full-screen clear.
- Emits one pixel per cycle to the VGA frame-buffer writer, with valid/ready backpressure and start/busy/done command handshake.
- Off-screen pixels are clipped rather than wrapped.
- Sits between the mouse-position/button logic and vga_adapter.

Parameters:
- SCREEN_W, 320, frame width in pixels.
- SCREEN_H, 240, frame height in pixels.
- MAX_BRUSH, 31, largest brush edge in pixels; the size input is clamped to this.
- COLOR_W, 9, pixel colour width.
- BG_COLOR, 9'h1FF, colour written by clear.
- Derived (localparams): X_W=$clog2(SCREEN_W)=9, Y_W=$clog2(SCREEN_H)=8, S_W=$clog2(MAX_BRUSH+1)=5.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a brush stamp; sampled in IDLE only.
- clear_req  in  1  request a full-screen clear; sampled in IDLE only.
- cur_x  in  X_W  brush centre X, latched on accept.
- cur_y  in  Y_W  brush centre Y, latched on accept.
- brush_size  in  S_W  brush edge length, latched on accept.
- brush_color  in  COLOR_W  stamp colour, latched on accept.
- shape  in  1  0=square, 1=disc; latched on accept; ignored without the macro.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- pix_valid  out  1  pix_x/pix_y/pix_color hold a pixel to write.
- pix_ready  in  1  downstream accepts the pixel when pix_valid && pix_ready.
- pix_x  out  X_W  pixel X.
- pix_y  out  Y_W  pixel Y.
- pix_color  out  COLOR_W  pixel colour.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, pix_valid=0, pix_x=0, pix_y=0, pix_color=BG_COLOR; latched command registers cleared.
- States: IDLE, STAMP, CLEAR, DONE.
- IDLE: clear_req=1 → CLEAR (clear wins if start is also high). Else start=1 → STAMP. Accepting latches cx, cy, size, colour and shape, and zeroes ox/oy.
- Effective size: s = (brush_size==0) ? 1 : min(brush_size, MAX_BRUSH). Centre offset c = (s-1)>>1.
- STAMP scan order is row-major: ox runs 0..s-1 inside oy 0..s-1.
  - Candidate pixel: px = cx + ox - c, py = cy + oy - c, computed signed with X_W+1 / Y_W+1 bits.
  - Candidate is written iff 0<=px<SCREEN_W and 0<=py<SCREEN_H (and it passes the disc test when enabled).
  - Each candidate takes exactly one cycle whether written or skipped, plus one extra cycle per cycle of backpressure.
- Output register: a written candidate is loaded into pix_* with pix_valid=1 one cycle after evaluation. pix_valid/pix_* hold stable while pix_ready=0, and the scan counter stalls while the held pixel is unaccepted.
- A skipped candidate leaves pix_valid=0 for that slot.
- Latency: first pix_valid rises 2 cycles after the accept edge, or later if the first candidates are clipped.
- CLEAR: scans x 0..SCREEN_W-1 inside y 0..SCREEN_H-1 with colour BG_COLOR. Same output/stall rules; no clipping.
- DONE: entered once the final pixel has been accepted, or once the final candidate is skipped. Pulses done=1 and drops busy in the same cycle, then returns to IDLE. New start/clear_req are sampled on the following cycle.
- start/clear_req while busy are ignored (not queued).
- Input changes after accept have no effect on the operation in flight.
- resetn asserted mid-operation: immediate abort, all outputs take their reset values, and no partial done is issued.

Optional Feature:
- Macro: PAINT_BRUSH_DISC_EN.
- Defined: when shape=1, a candidate is additionally kept only if u²+v² <= s², with u=2·ox-(s-1) and v=2·oy-(s-1) (unsigned 2·S_W+2-bit compare). Rejected candidates are skipped like clipped ones.
- Undefined: shape is ignored, every stamp is square, and no multiplier is instantiated.

Decomposition:
- paint_pkg holds the state enum (IDLE/STAMP/CLEAR/DONE), default SCREEN_W/SCREEN_H/BG_COLOR, and the clamp-size function.
- One natural sub-module, raster_scan_counter: a 2-D counter with programmable X/Y limits, an advance enable, and a last-element flag. One instance is shared by STAMP (limits s,s) and CLEAR (limits SCREEN_W,SCREEN_H).

Test Plan:
- Square, on-screen: pix_ready=1, start with (100,50), size 3, colour 9'h007 → 9 pixels, x 99..101 × y 49..51, row-major, all colour 9'h007; done exactly 1 cycle after the last accept.
- Corner clip: size 20 at (0,0), c=9 → 121 writes covering x,y 0..10, none negative or wrapped; 400 scan cycles in total.
- Backpressure: size 3 stamp with pix_ready toggled 1/0 every cycle → same 9 pixels in order, no duplicates or drops; pix_* stable while stalled.
- Clear plus priority: start and clear_req in the same cycle → 76800 pixels of 9'h1FF, first (0,0), last (319,239); a start issued while busy is ignored.
- Size edges and reset: size 0 → 1 pixel at the centre; size 31 at (319,239) → 16×16 on-screen writes. resetn pulsed mid-stamp → pix_valid=0 and busy=0 immediately; no done.
- Disc (PAINT_BRUSH_DISC_EN defined): shape=1, size 5 at (50,50) → 21 pixels, corners (48,48), (52,48), (48,52), (52,52) absent.
